// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, PC_control encodings and loader states for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam int unsigned IRAM_DEPTH = 256;
  localparam int unsigned IADDR_W    = 8;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned COUNT_W    = 16;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_JUMP = 2'b10
  } pc_ctrl_e;

  typedef enum logic [2:0] {
    LD_HDR_HI,
    LD_HDR_LO,
    LD_DATA_HI,
    LD_DATA_LO,
    LD_RUN
  } ld_state_e;

endpackage

// File: rtl/iram_256x16.sv
// 256 x 16 instruction RAM, synchronous write and synchronous (read-before-write) read.
module iram_256x16
  import instruction_fetch_unit_pkg::*;
(
  input  logic               clock,
  input  logic               we,
  input  logic [IADDR_W-1:0] addr,
  input  logic [INSTR_W-1:0] wdata,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [IRAM_DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// UART program loader, program counter and instruction register around the IRAM.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  input  logic               load_instruction,
  input  logic [1:0]         PC_control,
  output logic [INSTR_W-1:0] instruction,
  output logic [IADDR_W-1:0] PC,
  output logic               enable_processor,
  output logic               loader_busy
);

  localparam int unsigned WCNT_W = IADDR_W + 1;

  ld_state_e          state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [IADDR_W-1:0] waddr_q, waddr_d;
  logic [BYTE_W-1:0]  word_hi_q, word_hi_d;
  logic [IADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               fresh_q, fresh_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;

  logic               iram_we;
  logic [IADDR_W-1:0] iram_addr;
  logic [INSTR_W-1:0] iram_wdata;
  logic [INSTR_W-1:0] iram_rdata;
  logic [WCNT_W-1:0]  words_total_c;
  logic               last_word_c;

  iram_256x16 u_iram (
    .clock (clock),
    .we    (iram_we),
    .addr  (iram_addr),
    .wdata (iram_wdata),
    .rdata (iram_rdata)
  );

  // Loader owns the RAM address until RUN, then the PC does.
  assign iram_addr  = (state_q == LD_RUN) ? pc_q : waddr_q;
  assign iram_wdata = {word_hi_q, rx_data};

  // Headers above the RAM depth are clipped to a full RAM.
  assign words_total_c = (count_q > COUNT_W'(IRAM_DEPTH)) ? WCNT_W'(IRAM_DEPTH)
                                                          : count_q[WCNT_W-1:0];
  assign last_word_c   = ((WCNT_W'(waddr_q) + WCNT_W'(1)) == words_total_c);

  // Right after a load edge the RAM read port already holds IRAM[old PC];
  // it is copied into instr_q on the next edge so the value survives PC moves.
  assign instruction      = fresh_q ? iram_rdata : instr_q;
  assign PC               = pc_q;
  assign enable_processor = en_q;
  assign loader_busy      = busy_q;

  // Loader next state.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    waddr_d   = waddr_q;
    word_hi_d = word_hi_q;
    iram_we   = 1'b0;
    if (rx_valid) begin
      case (state_q)
        LD_HDR_HI: begin
          count_d = {rx_data, count_q[BYTE_W-1:0]};
          state_d = LD_HDR_LO;
        end
        LD_HDR_LO: begin
          count_d = {count_q[COUNT_W-1:BYTE_W], rx_data};
          state_d = ({count_q[COUNT_W-1:BYTE_W], rx_data} == COUNT_W'(0)) ? LD_RUN
                                                                           : LD_DATA_HI;
        end
        LD_DATA_HI: begin
          word_hi_d = rx_data;
          state_d   = LD_DATA_LO;
        end
        LD_DATA_LO: begin
          iram_we = 1'b1;
          waddr_d = waddr_q + IADDR_W'(1);
          state_d = last_word_c ? LD_RUN : LD_DATA_HI;
        end
        default: ;
      endcase
    end
    en_d   = (state_d == LD_RUN);
    busy_d = (state_d != LD_RUN);
  end

  // PC and instruction register next state; inert until the program is loaded.
  always_comb begin
    pc_d    = pc_q;
    instr_d = fresh_q ? iram_rdata : instr_q;
    fresh_d = 1'b0;
    if (en_q) begin
      fresh_d = load_instruction;
      case (pc_ctrl_e'(PC_control))
        PC_INC:  pc_d = pc_q + IADDR_W'(1);
        PC_JUMP: pc_d = instruction[IADDR_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LD_HDR_HI;
      count_q   <= '0;
      waddr_q   <= '0;
      word_hi_q <= '0;
      pc_q      <= '0;
      instr_q   <= '0;
      fresh_q   <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      waddr_q   <= waddr_d;
      word_hi_q <= word_hi_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      fresh_q   <= fresh_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_instruction_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        load_instruction;
  logic [1:0]  PC_control;
  logic [15:0] instruction;
  logic [7:0]  PC;
  logic        enable_processor;
  logic        loader_busy;

  localparam int SEL_INSTR = 0;
  localparam int SEL_PC    = 1;
  localparam int SEL_EN    = 2;
  localparam int SEL_BUSY  = 3;
  localparam int SEL_MEM   = 4;
  localparam int SEL_WRCNT = 5;

  typedef struct {
    string       name;
    int          sel;
    int          addr;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] mon_act;
  int          checks  = 0;
  int          passed  = 0;
  int          wr_cnt  = 0;
  int          wr_base = 0;

  instruction_fetch_unit dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .load_instruction (load_instruction),
    .PC_control       (PC_control),
    .instruction      (instruction),
    .PC               (PC),
    .enable_processor (enable_processor),
    .loader_busy      (loader_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (dut.u_iram.we) wr_cnt = wr_cnt + 1;
  end

  // Monitor: compare every queued expectation at the negedge after it was issued.
  always @(negedge clock) begin
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      case (mon_e.sel)
        SEL_INSTR: mon_act = instruction;
        SEL_PC:    mon_act = 16'(PC);
        SEL_EN:    mon_act = 16'(enable_processor);
        SEL_BUSY:  mon_act = 16'(loader_busy);
        SEL_MEM:   mon_act = dut.u_iram.mem[mon_e.addr[7:0]];
        default:   mon_act = 16'(wr_cnt - wr_base);
      endcase
      checks = checks + 1;
      if (mon_act === mon_e.exp) passed = passed + 1;
      else $display("FAIL %s: actual %h expected %h", mon_e.name, mon_act, mon_e.exp);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string n, input int s, input int a, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.addr = a;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instr"}, SEL_INSTR, 0, 16'h0000);
    chk({tag, "_pc"},    SEL_PC,    0, 16'h0000);
    chk({tag, "_en"},    SEL_EN,    0, 16'h0000);
    chk({tag, "_busy"},  SEL_BUSY,  0, 16'h0001);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clock); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [1:0] pcc);
    @(posedge clock); #1;
    load_instruction = ld;
    PC_control       = pcc;
    @(posedge clock); #1;
    load_instruction = 1'b0;
    PC_control       = 2'b00;
  endtask

  // Assert reset mid-cycle so the checks land before any further clock edge.
  task automatic do_reset(input string tag);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals(tag);
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b1;
    wr_base = wr_cnt;
  endtask

  initial begin
    reset_n          = 1'b0;
    rx_data          = 8'h00;
    rx_valid         = 1'b0;
    load_instruction = 1'b0;
    PC_control       = 2'b00;
    #1;
    chk_reset_vals("por");
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    wr_base = wr_cnt;

    // Fetch controls must be inert while loading.
    @(posedge clock); #1;
    load_instruction = 1'b1;
    PC_control       = 2'b01;
    repeat (3) @(posedge clock);
    #1;
    load_instruction = 1'b0;
    PC_control       = 2'b00;
    chk("ignore_pc", SEL_PC, 0, 16'h0000);
    chk("ignore_instr", SEL_INSTR, 0, 16'h0000);

    // Two-word program, then two fetch+increment cycles.
    send(8'h00); send(8'h02); send(8'hC0); send(8'h05); send(8'h40);
    chk("a_en_before_last", SEL_EN, 0, 16'h0000);
    chk("a_busy_before_last", SEL_BUSY, 0, 16'h0001);
    send(8'h00);
    chk("a_en_after_last", SEL_EN, 0, 16'h0001);
    chk("a_busy_after_last", SEL_BUSY, 0, 16'h0000);
    chk("a_mem0", SEL_MEM, 0, 16'hC005);
    chk("a_mem1", SEL_MEM, 1, 16'h4000);
    chk("a_writes", SEL_WRCNT, 0, 16'h0002);
    step(1'b1, 2'b01);
    chk("a_fetch1_instr", SEL_INSTR, 0, 16'hC005);
    chk("a_fetch1_pc", SEL_PC, 0, 16'h0001);
    step(1'b1, 2'b01);
    chk("a_fetch2_instr", SEL_INSTR, 0, 16'h4000);
    chk("a_fetch2_pc", SEL_PC, 0, 16'h0002);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    chk("a_hold_instr", SEL_INSTR, 0, 16'h4000);
    chk("a_hold_pc", SEL_PC, 0, 16'h0002);

    do_reset("rst_run");
    chk("iram_kept", SEL_MEM, 0, 16'hC005);

    // Empty program.
    send(8'h00);
    chk("b_en_after_1", SEL_EN, 0, 16'h0000);
    send(8'h00);
    chk("b_en_after_2", SEL_EN, 0, 16'h0001);
    chk("b_busy_after_2", SEL_BUSY, 0, 16'h0000);
    chk("b_writes", SEL_WRCNT, 0, 16'h0000);

    // Abandoned load followed by a fresh one.
    do_reset("rst_b");
    send(8'h00); send(8'h02); send(8'h55);
    do_reset("rst_mid");
    send(8'h00); send(8'h01); send(8'h12);
    chk("c_en_before_last", SEL_EN, 0, 16'h0000);
    send(8'h34);
    chk("c_en", SEL_EN, 0, 16'h0001);
    chk("c_mem0", SEL_MEM, 0, 16'h1234);
    chk("c_writes", SEL_WRCNT, 0, 16'h0001);
    step(1'b1, 2'b00);
    chk("c_fetch_instr", SEL_INSTR, 0, 16'h1234);
    chk("c_fetch_pc", SEL_PC, 0, 16'h0000);

    // Oversized header 0x0105: 256 words of {40, i+23}, then 4 stray bytes.
    do_reset("rst_c");
    send(8'h01); send(8'h05);
    for (int i = 0; i < 256; i++) begin
      send(8'h40);
      if (i == 255) chk("d_en_before_last", SEL_EN, 0, 16'h0000);
      send(8'(i + 8'h23));
    end
    chk("d_en", SEL_EN, 0, 16'h0001);
    chk("d_busy", SEL_BUSY, 0, 16'h0000);
    chk("d_writes", SEL_WRCNT, 0, 16'h0100);
    chk("d_mem0", SEL_MEM, 0, 16'h4023);
    chk("d_mem255", SEL_MEM, 255, 16'h4022);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("d_extra_writes", SEL_WRCNT, 0, 16'h0100);
    chk("d_extra_mem0", SEL_MEM, 0, 16'h4023);
    chk("d_extra_mem1", SEL_MEM, 1, 16'h4024);
    chk("d_extra_en", SEL_EN, 0, 16'h0001);
    chk("d_extra_pc", SEL_PC, 0, 16'h0000);

    // Jumps, wrap and combined load+update.
    step(1'b1, 2'b00);
    chk("e_load0_instr", SEL_INSTR, 0, 16'h4023);
    chk("e_load0_pc", SEL_PC, 0, 16'h0000);
    step(1'b0, 2'b10);
    chk("e_jump_pc", SEL_PC, 0, 16'h0023);
    step(1'b1, 2'b10);
    chk("e_ldjump_instr", SEL_INSTR, 0, 16'h4046);
    chk("e_ldjump_pc", SEL_PC, 0, 16'h0023);
    step(1'b0, 2'b10);
    chk("e_jump2_pc", SEL_PC, 0, 16'h0046);
    repeat (185) step(1'b0, 2'b01);
    chk("e_pc_ff", SEL_PC, 0, 16'h00FF);
    step(1'b0, 2'b01);
    chk("e_pc_wrap", SEL_PC, 0, 16'h0000);
    repeat (5) step(1'b0, 2'b01);
    chk("e_pc_5", SEL_PC, 0, 16'h0005);
    step(1'b1, 2'b01);
    chk("e_ldinc_instr", SEL_INSTR, 0, 16'h4028);
    chk("e_ldinc_pc", SEL_PC, 0, 16'h0006);
    step(1'b0, 2'b11);
    chk("e_hold11_pc", SEL_PC, 0, 16'h0006);
    chk("e_hold11_instr", SEL_INSTR, 0, 16'h4028);

    @(negedge clock); #1;
    if (sb.size() != 0) begin
      checks = checks + 1;
      $display("FAIL scoreboard_drain: actual %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clock and reset_n.
REQ-002 The block SHALL have these ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  async active-low reset.
- rx_data  in  8  program byte from the UART receiver.
- rx_valid  in  1  single-cycle strobe, rx_data valid.
- load_instruction  in  1  from the control state machine; capture IRAM[PC] into instruction.
- PC_control  in  2  00 hold, 01 increment, 10 jump, 11 hold.
- instruction  out  16  instruction register; feeds the control state machine and the datapath.
- PC  out  8  program counter.
- enable_processor  out  1  program loaded, processor may run.
- loader_busy  out  1  loader is accepting bytes.

Function
REQ-003 The block SHALL contain a 256 x 16 instruction RAM: synchronous write, synchronous read.
REQ-004 The loader FSM SHALL have these states, each advancing only on an rx_valid cycle:
- HDR_HI: byte -> count[15:8]; next HDR_LO.
- HDR_LO: byte -> count[7:0]; next DATA_HI, or RUN if the 16-bit count is 0.
- DATA_HI: byte -> word[15:8]; next DATA_LO.
- DATA_LO: write {word_hi, byte} to IRAM[waddr]; increment waddr; next DATA_HI, or RUN once the written total equals min(count, 256).
- RUN: terminal until reset.
REQ-005 Program words SHALL be sent high byte first; waddr SHALL start at 0.
REQ-006 If count > 256, exactly 256 words SHALL be written and then RUN entered; any further bytes SHALL be ignored.
REQ-007 loader_busy SHALL be 1 in HDR_HI..DATA_LO and 0 in RUN.
REQ-008 enable_processor SHALL assert on the clock edge that enters RUN and stay high until reset.
REQ-009 rx_valid SHALL be ignored in RUN.
REQ-010 load_instruction and PC_control SHALL be ignored while enable_processor = 0.
REQ-011 In RUN, load_instruction = 1 at a posedge SHALL make instruction equal IRAM[PC] after that edge (one-cycle latency; the control state machine samples it at the following negedge).
REQ-012 In RUN, PC_control SHALL act at each posedge:
- 01: PC <= PC + 1, modulo 256 (255 -> 0).
- 10: PC <= instruction[7:0].
- 00 or 11: PC holds.
REQ-013 If load_instruction and PC_control != 00 occur in the same cycle, the read SHALL use the pre-update PC and the PC update SHALL also take effect.
REQ-014 Jump SHALL use the instruction register contents held before that edge.
REQ-015 instruction SHALL hold its value whenever load_instruction = 0.

Reset
REQ-016 Asserting reset_n low SHALL immediately force:
- loader state HDR_HI, count 0, waddr 0;
- PC 0, instruction 16'h0000;
- enable_processor 0, loader_busy 1.
REQ-017 IRAM contents SHALL NOT be cleared by reset.
REQ-018 A reset mid-load SHALL abandon the load; the next byte received SHALL be taken as a new header high byte.
REQ-019 Reset SHALL be released synchronously to clock by the system; the block SHALL require no internal synchroniser.

Structure
REQ-020 A shared package SHALL hold:
- IRAM_DEPTH = 256, IADDR_W = 8, INSTR_W = 16;
- PC_control encodings (HOLD, INC, JUMP);
- the loader state enum.
The control state machine SHALL use the same PC_control encodings.
REQ-021 The IRAM SHALL be a separate sub-module, iram_256x16, with ports clock, we, addr, wdata, rdata; the loader owns addr during load and PC owns it in RUN.
REQ-022 Loader FSM, PC register and instruction register SHALL be in instruction_fetch_unit.

Verification
REQ-023 Load bytes 00 02 C0 05 40 00, then fetch twice with INC:
- IRAM[0] = C005, IRAM[1] = 4000;
- enable_processor rises after the 6th byte;
- the fetches return instruction C005 then 4000, PC ends at 2.
REQ-024 Header 00 00 -> enable_processor = 1 after the 2nd byte; no IRAM write.
REQ-025 Header 01 05 followed by 512 data bytes, then 4 more bytes:
- exactly 256 writes occur and RUN is entered;
- the 4 extra bytes change nothing.
REQ-026 PC = 255 with PC_control = 01 -> PC = 0. Instruction 4023 loaded, then PC_control = 10 -> PC = 8'h23.
REQ-027 load_instruction = 1 and PC_control = 01 in the same cycle at PC = 5 -> instruction = IRAM[5] and PC = 6.
REQ-028 reset_n pulsed low after 3 bytes of a 2-word load:
- outputs return to reset values immediately;
- a fresh 00 01 1234 load yields IRAM[0] = 1234 and enable_processor = 1.
